// File: rtl/game_timer_bcd.sv
// Game timer: elapsed/best run time in binary and packed BCD, start/pause/over FSM.
// Define GAME_TIMER_BLANK_EN to blank leading zero digits (4'hF) on the BCD outputs.
module game_timer_bcd #(
    parameter int TICK_PERIOD = 25_000_000,
    parameter int NUM_DIGITS  = 4,
    parameter int COUNT_WIDTH = 14,
    parameter int PRESC_WIDTH = 25
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    game_over,
    input  logic                    clear_best,
    output logic [COUNT_WIDTH-1:0]  elapsed,
    output logic [4*NUM_DIGITS-1:0] elapsed_bcd,
    output logic [COUNT_WIDTH-1:0]  best,
    output logic [4*NUM_DIGITS-1:0] best_bcd,
    output logic                    unit_tick,
    output logic                    new_best,
    output logic                    running,
    output logic                    saturated,
    output logic [1:0]              state
);

    localparam int BW = 4 * NUM_DIGITS;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT  = COUNT_WIDTH'(pow10(NUM_DIGITS) - 1);
    localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(TICK_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_WIDTH-1:0] presc;
    logic [BW-1:0]          elapsed_bcd_q;
    logic [BW-1:0]          best_bcd_q;
    logic                   do_clear;
    logic                   do_count;
    logic                   to_over;
    logic                   wrap;

    // Ripple +1 across digits; never called at the saturation value.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        logic [3:0]    d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_clear = 1'b0;
        do_count = 1'b0;
        to_over  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    do_clear = 1'b1;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = OVER;
                    to_over = 1'b1;
                end else if (pause) begin
                    state_d = PAUSED;
                end else begin
                    do_count = 1'b1;
                end
            end
            PAUSED: begin
                if (game_over) begin
                    state_d = OVER;
                    to_over = 1'b1;
                end else if (pause) begin
                    state_d = RUN;
                end
            end
            OVER: begin
                if (start && !game_over) begin
                    state_d  = RUN;
                    do_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wrap = do_count && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            presc         <= '0;
            elapsed       <= '0;
            elapsed_bcd_q <= '0;
            saturated     <= 1'b0;
            unit_tick     <= 1'b0;
        end else begin
            unit_tick <= 1'b0;
            if (do_clear) begin
                presc         <= '0;
                elapsed       <= '0;
                elapsed_bcd_q <= '0;
                saturated     <= 1'b0;
            end else if (wrap) begin
                presc     <= '0;
                unit_tick <= 1'b1;
                if (elapsed != MAX_COUNT) begin
                    elapsed       <= elapsed + COUNT_WIDTH'(1);
                    elapsed_bcd_q <= bcd_inc(elapsed_bcd_q);
                    if (elapsed + COUNT_WIDTH'(1) == MAX_COUNT) saturated <= 1'b1;
                end
            end else if (do_count) begin
                presc <= presc + PRESC_WIDTH'(1);
            end
        end
    end

    // A record on the game-over edge takes precedence over clear_best.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            best       <= '0;
            best_bcd_q <= '0;
            new_best   <= 1'b0;
            running    <= 1'b0;
        end else begin
            new_best <= 1'b0;
            running  <= (state_d == RUN);
            if (to_over && (elapsed > best)) begin
                best       <= elapsed;
                best_bcd_q <= elapsed_bcd_q;
                new_best   <= 1'b1;
            end else if (clear_best) begin
                best       <= '0;
                best_bcd_q <= '0;
            end
        end
    end

    assign state = state_q;

`ifdef GAME_TIMER_BLANK_EN
    function automatic logic [BW-1:0] blank(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          lead;
        r    = v;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (v[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
            else                               lead = 1'b0;
        end
        return r;
    endfunction

    assign elapsed_bcd = blank(elapsed_bcd_q);
    assign best_bcd    = blank(best_bcd_q);
`else
    assign elapsed_bcd = elapsed_bcd_q;
    assign best_bcd    = best_bcd_q;
`endif

endmodule

// File: tb/tb_game_timer_bcd.sv
// Scoreboard bench for game_timer_bcd (TICK_PERIOD=4, NUM_DIGITS=2).
// Expected tick/new_best events are queued by stimulus and popped by monitors.
module tb_game_timer_bcd;

    logic       clk;
    logic       resetN;
    logic       start, pause, game_over, clear_best;
    logic [6:0] elapsed, best;
    logic [7:0] elapsed_bcd, best_bcd;
    logic       unit_tick, new_best, running, saturated;
    logic [1:0] state;

    game_timer_bcd #(
        .TICK_PERIOD(4),
        .NUM_DIGITS (2),
        .COUNT_WIDTH(7),
        .PRESC_WIDTH(3)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .pause      (pause),
        .game_over  (game_over),
        .clear_best (clear_best),
        .elapsed    (elapsed),
        .elapsed_bcd(elapsed_bcd),
        .best       (best),
        .best_bcd   (best_bcd),
        .unit_tick  (unit_tick),
        .new_best   (new_best),
        .running    (running),
        .saturated  (saturated),
        .state      (state)
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t tick_q[$];
    int   best_q[$];
    exp_t mon_e;
    int   mon_b;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   e0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bin2bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [7:0] exp_bcd(input logic [7:0] raw);
`ifdef GAME_TIMER_BLANK_EN
        if (raw[7:4] == 4'd0) return {4'hF, raw[3:0]};
`endif
        return raw;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_ticks(input int first, input int last, input int base);
        for (int v = first; v <= last; v++)
            tick_q.push_back('{val: v, cyc: base + 4 * (v - first + 1)});
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic restart();
        game_over = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic go_over();
        game_over = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            if (unit_tick) begin
                if (tick_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tick: elapsed=%0d cycle=%0d, none expected",
                             elapsed, cyc);
                end else begin
                    mon_e = tick_q.pop_front();
                    check("tick_elapsed", 32'(elapsed), 32'(mon_e.val));
                    check("tick_bcd", 32'(elapsed_bcd), 32'(exp_bcd(bin2bcd(mon_e.val))));
                    check("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
            if (new_best) begin
                if (best_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_new_best: best=%0d cycle=%0d, none expected",
                             best, cyc);
                end else begin
                    mon_b = best_q.pop_front();
                    check("new_best_value", 32'(best), 32'(mon_b));
                    check("new_best_bcd", 32'(best_bcd), 32'(exp_bcd(bin2bcd(mon_b))));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resetN     = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        game_over  = 1'b0;
        clear_best = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_elapsed", 32'(elapsed), 0);
        check("rst_elapsed_bcd", 32'(elapsed_bcd), 32'(exp_bcd(8'h00)));
        check("rst_best", 32'(best), 0);
        check("rst_flags", {28'd0, unit_tick, new_best, running, saturated}, 0);
        resetN = 1'b1;

        // 1: plain counting, 10 units in 40 cycles
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        push_ticks(1, 10, e0);
        wait_to(e0 + 40);
        check("s1_elapsed", 32'(elapsed), 10);
        check("s1_bcd", 32'(elapsed_bcd), 32'h10);
        check("s1_state", 32'(state), 1);
        check("s1_running", 32'(running), 1);
        best_q.push_back(10);
        go_over();
        check("s1_over", 32'(state), 3);

        // 2: pause mid-unit, prescaler resumes from 1
        restart();
        push_ticks(1, 2, e0);
        wait_to(e0 + 9);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("s2_paused", 32'(state), 2);
        check("s2_running", 32'(running), 0);
        wait_to(e0 + 30);
        check("s2_held", 32'(elapsed), 2);
        push_ticks(3, 4, e0 + 30);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        wait_to(e0 + 38);
        check("s2_elapsed", 32'(elapsed), 4);
        check("s2_state", 32'(state), 1);
        go_over();
        check("s2_best_kept", 32'(best), 10);

        // 3: saturation at 99
        restart();
        push_ticks(1, 99, e0);
        wait_to(e0 + 396);
        check("s3_elapsed", 32'(elapsed), 99);
        check("s3_saturated", 32'(saturated), 1);
        tick_q.push_back('{val: 99, cyc: e0 + 400});
        wait_to(e0 + 400);
        check("s3_sat_hold", 32'(elapsed), 99);
        best_q.push_back(99);
        go_over();
        check("s3_state", 32'(state), 3);
        check("s3_best", 32'(best), 99);
        check("s3_best_bcd", 32'(best_bcd), 32'h99);
        check("s3_sat_over", 32'(saturated), 1);

        // 4: best tracking, equal no update, clear_best
        clear_best = 1'b1;
        @(negedge clk);
        clear_best = 1'b0;
        check("s4_clear0", 32'(best), 0);
        restart();
        push_ticks(1, 5, e0);
        wait_to(e0 + 20);
        best_q.push_back(5);
        go_over();
        check("s4_run1", 32'(best), 5);
        restart();
        push_ticks(1, 3, e0);
        wait_to(e0 + 12);
        go_over();
        check("s4_run2", 32'(best), 5);
        restart();
        push_ticks(1, 5, e0);
        wait_to(e0 + 20);
        go_over();
        check("s4_run3_equal", 32'(best), 5);
        clear_best = 1'b1;
        @(negedge clk);
        clear_best = 1'b0;
        check("s4_clear", 32'(best), 0);
        check("s4_clear_bcd", 32'(best_bcd), 32'(exp_bcd(8'h00)));
        restart();
        push_ticks(1, 2, e0);
        wait_to(e0 + 8);
        best_q.push_back(2);
        clear_best = 1'b1;
        game_over  = 1'b1;
        @(negedge clk);
        clear_best = 1'b0;
        check("s4_update_wins", 32'(best), 2);

        // 5: game_over on the wrap of unit 3, start blocked by game_over
        restart();
        push_ticks(1, 2, e0);
        wait_to(e0 + 11);
        go_over();
        check("s5_elapsed", 32'(elapsed), 2);
        check("s5_state", 32'(state), 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s5_ignored_state", 32'(state), 3);
        check("s5_ignored_elapsed", 32'(elapsed), 2);
        game_over = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        check("s5_restart_elapsed", 32'(elapsed), 0);
        check("s5_restart_state", 32'(state), 1);
        check("s5_restart_bcd", 32'(elapsed_bcd), 32'(exp_bcd(8'h00)));

        // pause on a wrap cycle suppresses the increment and holds the prescaler
        push_ticks(1, 7, e0 + 3);
        wait_to(e0 + 3);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("s5_pause_wrap", 32'(elapsed), 0);
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        wait_to(e0 + 31);
        check("s6_elapsed", 32'(elapsed), 7);
        check("s6_bcd", 32'(elapsed_bcd), 32'(exp_bcd(8'h07)));

        // 6: asynchronous reset between edges
        #2;
        resetN = 1'b0;
        #1;
        check("s6_rst_elapsed", 32'(elapsed), 0);
        check("s6_rst_bcd", 32'(elapsed_bcd), 32'(exp_bcd(8'h00)));
        check("s6_rst_best", 32'(best), 0);
        check("s6_rst_best_bcd", 32'(best_bcd), 32'(exp_bcd(8'h00)));
        check("s6_rst_state", 32'(state), 0);
        check("s6_rst_flags", {28'd0, unit_tick, new_best, running, saturated}, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        check("tick_queue_drained", 32'(tick_q.size()), 0);
        check("best_queue_drained", 32'(best_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
